// File: rtl/eeg_fram_pkg.sv
// Shared definitions for the FRAM bank initiator: opcodes and one-hot FSM states.
package eeg_fram_pkg;

  localparam logic OPC_WR = 1'b0;
  localparam logic OPC_RD = 1'b1;

  typedef enum logic [3:0] {
    MST_IDLE = 4'b0001,
    MST_WR   = 4'b0010,
    MST_RD   = 4'b0100,
    MST_DRN  = 4'b1000
  } mst_state_e;

endpackage

// File: rtl/eeg_fram_rfifo.sv
// Return-data FIFO: {data, expected_last} entries, head served from the storage registers.
module eeg_fram_rfifo
  import eeg_fram_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/eeg_fram_mst.sv
// Engine-side FRAM bank initiator: burst writes from the source stream, credit-limited
// burst reads returned through a small FIFO to the sink stream.
module eeg_fram_mst
  import eeg_fram_pkg::*;
#(
  parameter int unsigned ADD_AW  = 12,
  parameter int unsigned DAT_DW  = 4,
  parameter int unsigned LEN_DW  = 12,
  parameter int unsigned OSD_NUM = 4,
  parameter int unsigned OSD_AW  = $clog2(OSD_NUM + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              IS_IDLE,
  input  logic              CMD_VLD,
  output logic              CMD_RDY,
  input  logic              CMD_OPC,
  input  logic [ADD_AW-1:0] CMD_ADD,
  input  logic [LEN_DW-1:0] CMD_LEN,
  input  logic              SRC_VLD,
  output logic              SRC_RDY,
  input  logic [DAT_DW-1:0] SRC_DAT,
  output logic              ETOF_DAT_VLD,
  output logic              ETOF_DAT_LST,
  input  logic              ETOF_DAT_RDY,
  output logic [ADD_AW-1:0] ETOF_DAT_ADD,
  output logic [DAT_DW-1:0] ETOF_DAT_DAT,
  output logic              ETOF_ADD_VLD,
  output logic              ETOF_ADD_LST,
  input  logic              ETOF_ADD_RDY,
  output logic [ADD_AW-1:0] ETOF_ADD_ADD,
  input  logic              FTOE_DAT_VLD,
  input  logic              FTOE_DAT_LST,
  output logic              FTOE_DAT_RDY,
  input  logic [DAT_DW-1:0] FTOE_DAT_DAT,
  output logic              SNK_VLD,
  output logic              SNK_LST,
  input  logic              SNK_RDY,
  output logic [DAT_DW-1:0] SNK_DAT,
  output logic              ERR_LST
);

  mst_state_e        state_q;
  logic [ADD_AW-1:0] base_q;
  logic [LEN_DW-1:0] len_q, wcnt_q, acnt_q, rcnt_q;
  logic [OSD_AW-1:0] credit_q;
  logic              err_q;

  logic st_idle, st_wr, st_rd, st_drn;
  logic wr_hs, add_hs, push, pop, bad_push, exp_lst;
  logic fifo_empty, fifo_full;
  logic [DAT_DW:0] fifo_dout;

  assign st_idle = (state_q == MST_IDLE);
  assign st_wr   = (state_q == MST_WR);
  assign st_rd   = (state_q == MST_RD);
  assign st_drn  = (state_q == MST_DRN);

  assign IS_IDLE = st_idle;
  assign CMD_RDY = st_idle;

  // Write channel is a pure pass-through of the source stream while in WR.
  assign ETOF_DAT_VLD = st_wr && SRC_VLD;
  assign SRC_RDY      = st_wr && ETOF_DAT_RDY;
  assign ETOF_DAT_DAT = SRC_DAT;
  assign ETOF_DAT_ADD = base_q + ADD_AW'(wcnt_q);
  assign ETOF_DAT_LST = st_wr && (wcnt_q == len_q);
  assign wr_hs        = ETOF_DAT_VLD && ETOF_DAT_RDY;

  assign ETOF_ADD_VLD = st_rd && (credit_q != '0);
  assign ETOF_ADD_ADD = base_q + ADD_AW'(acnt_q);
  assign ETOF_ADD_LST = st_rd && (acnt_q == len_q);
  assign add_hs       = ETOF_ADD_VLD && ETOF_ADD_RDY;

  // Returned data cannot be stalled; credits guarantee FIFO room for every push.
  assign FTOE_DAT_RDY = 1'b1;
  assign exp_lst      = (rcnt_q == len_q);
  assign push         = FTOE_DAT_VLD && (st_rd || st_drn) && !fifo_full;
  assign bad_push     = FTOE_DAT_VLD && (st_idle || st_wr);

  assign SNK_VLD = !fifo_empty;
  assign SNK_DAT = fifo_dout[DAT_DW:1];
  assign SNK_LST = SNK_VLD && fifo_dout[0];
  assign pop     = SNK_VLD && SNK_RDY;
  assign ERR_LST = err_q;

  eeg_fram_rfifo #(
    .WIDTH(DAT_DW + 1),
    .DEPTH(OSD_NUM)
  ) u_rfifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  ({FTOE_DAT_DAT, exp_lst}),
    .pop  (pop),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MST_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      wcnt_q   <= '0;
      acnt_q   <= '0;
      rcnt_q   <= '0;
      credit_q <= OSD_AW'(OSD_NUM);
      err_q    <= 1'b0;
    end else begin
      if (push) rcnt_q <= rcnt_q + LEN_DW'(1);
      if ((push && (FTOE_DAT_LST != exp_lst)) || bad_push) err_q <= 1'b1;

      if (add_hs && !pop)      credit_q <= credit_q - OSD_AW'(1);
      else if (!add_hs && pop) credit_q <= credit_q + OSD_AW'(1);

      unique case (state_q)
        MST_IDLE: begin
          if (CMD_VLD) begin
            base_q  <= CMD_ADD;
            len_q   <= CMD_LEN;
            wcnt_q  <= '0;
            acnt_q  <= '0;
            rcnt_q  <= '0;
            state_q <= (CMD_OPC == OPC_RD) ? MST_RD : MST_WR;
          end
        end
        MST_WR: begin
          if (wr_hs) begin
            wcnt_q <= wcnt_q + LEN_DW'(1);
            if (wcnt_q == len_q) state_q <= MST_IDLE;
          end
        end
        MST_RD: begin
          if (add_hs) begin
            acnt_q <= acnt_q + LEN_DW'(1);
            if (acnt_q == len_q) state_q <= MST_DRN;
          end
        end
        MST_DRN: begin
          if (pop && fifo_dout[0]) state_q <= MST_IDLE;
        end
        default: state_q <= MST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeg_fram_mst.sv
// Scoreboard bench for eeg_fram_mst with a 2-cycle-latency FRAM model.
module tb_eeg_fram_mst;

  localparam int OSD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        IS_IDLE, CMD_VLD, CMD_RDY, CMD_OPC;
  logic [11:0] CMD_ADD, CMD_LEN;
  logic        SRC_VLD, SRC_RDY;
  logic [3:0]  SRC_DAT;
  logic        ETOF_DAT_VLD, ETOF_DAT_LST, ETOF_DAT_RDY;
  logic [11:0] ETOF_DAT_ADD;
  logic [3:0]  ETOF_DAT_DAT;
  logic        ETOF_ADD_VLD, ETOF_ADD_LST, ETOF_ADD_RDY;
  logic [11:0] ETOF_ADD_ADD;
  logic        FTOE_DAT_VLD, FTOE_DAT_LST, FTOE_DAT_RDY;
  logic [3:0]  FTOE_DAT_DAT;
  logic        SNK_VLD, SNK_LST, SNK_RDY;
  logic [3:0]  SNK_DAT;
  logic        ERR_LST;

  int tests_run = 0;
  int tests_failed = 0;
  logic err_exp = 1'b0;
  logic flip_en = 1'b0;
  logic [11:0] flip_addr = '0;

  bit [3:0] fram_mem [4096];
  bit [3:0] ref_mem [4096];
  logic [16:0] wq [$];
  logic [12:0] aq [$];
  logic [4:0]  sq [$];

  logic        p0_vld, p1_vld, p0_lst, p1_lst;
  logic [11:0] p0_add, p1_add;

  always #5 clk = ~clk;

  eeg_fram_mst dut (
    .clk(clk), .rst_n(rst_n), .IS_IDLE(IS_IDLE),
    .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_OPC(CMD_OPC), .CMD_ADD(CMD_ADD),
    .CMD_LEN(CMD_LEN), .SRC_VLD(SRC_VLD), .SRC_RDY(SRC_RDY), .SRC_DAT(SRC_DAT),
    .ETOF_DAT_VLD(ETOF_DAT_VLD), .ETOF_DAT_LST(ETOF_DAT_LST), .ETOF_DAT_RDY(ETOF_DAT_RDY),
    .ETOF_DAT_ADD(ETOF_DAT_ADD), .ETOF_DAT_DAT(ETOF_DAT_DAT),
    .ETOF_ADD_VLD(ETOF_ADD_VLD), .ETOF_ADD_LST(ETOF_ADD_LST), .ETOF_ADD_RDY(ETOF_ADD_RDY),
    .ETOF_ADD_ADD(ETOF_ADD_ADD), .FTOE_DAT_VLD(FTOE_DAT_VLD), .FTOE_DAT_LST(FTOE_DAT_LST),
    .FTOE_DAT_RDY(FTOE_DAT_RDY), .FTOE_DAT_DAT(FTOE_DAT_DAT),
    .SNK_VLD(SNK_VLD), .SNK_LST(SNK_LST), .SNK_RDY(SNK_RDY), .SNK_DAT(SNK_DAT),
    .ERR_LST(ERR_LST)
  );

  // FRAM model: stores writes, returns read data two cycles after the address handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_vld <= 1'b0;
      p1_vld <= 1'b0;
    end else begin
      if (ETOF_DAT_VLD && ETOF_DAT_RDY) fram_mem[ETOF_DAT_ADD] <= ETOF_DAT_DAT;
      p0_vld <= ETOF_ADD_VLD && ETOF_ADD_RDY;
      p0_add <= ETOF_ADD_ADD;
      p0_lst <= ETOF_ADD_LST ^ (flip_en && (ETOF_ADD_ADD == flip_addr));
      p1_vld <= p0_vld;
      p1_add <= p0_add;
      p1_lst <= p0_lst;
    end
  end

  assign FTOE_DAT_VLD = p1_vld;
  assign FTOE_DAT_LST = p1_lst;
  assign FTOE_DAT_DAT = fram_mem[p1_add];

  task automatic send_cmd(input logic opc, input logic [11:0] add, input logic [11:0] len);
    @(negedge clk);
    CMD_VLD = 1'b1; CMD_OPC = opc; CMD_ADD = add; CMD_LEN = len;
    #1;
    tests_run++;
    if (CMD_RDY !== 1'b1) begin
      tests_failed++;
      $display("FAIL cmd_rdy: got %b, want 1", CMD_RDY);
    end
    @(negedge clk);
    CMD_VLD = 1'b0;
    #1;
    tests_run++;
    if (IS_IDLE !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_after_cmd: IS_IDLE got %b, want 0", IS_IDLE);
    end
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    CMD_VLD = 0; CMD_OPC = 0; CMD_ADD = '0; CMD_LEN = '0; SRC_VLD = 0; SRC_DAT = '0;
    ETOF_DAT_RDY = 1; ETOF_ADD_RDY = 1; SNK_RDY = 0;
    #1 rst_n = 1'b0;
    #2;
    obs = {IS_IDLE, CMD_RDY, FTOE_DAT_RDY, ETOF_DAT_VLD, ETOF_DAT_LST, ETOF_ADD_VLD,
           ETOF_ADD_LST, SNK_VLD, SNK_LST, ERR_LST, SRC_RDY};
    tests_run++;
    if (obs !== 11'b111_0000_0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b, want 11100000000", obs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    err_exp = 1'b0;
  endtask

  task automatic run_write(input logic [11:0] base, input logic [11:0] len,
                           input logic [3:0] d0, input int rdy_pct);
    int sent = 0;
    int cyc = 0;
    logic [16:0] exp, got;
    wq.delete();
    for (int i = 0; i <= int'(len); i++) begin
      wq.push_back({base + 12'(i), 4'(d0 + 4'(i)), (i == int'(len))});
      ref_mem[base + 12'(i)] = 4'(d0 + 4'(i));
    end
    send_cmd(1'b0, base, len);
    while (sent <= int'(len) && cyc < 500) begin
      SRC_VLD = 1'b1;
      SRC_DAT = 4'(d0 + 4'(sent));
      ETOF_DAT_RDY = ($urandom_range(99) < rdy_pct);
      #1;
      tests_run++;
      if (SRC_RDY !== ETOF_DAT_RDY) begin
        tests_failed++;
        $display("FAIL src_rdy: got %b, want %b", SRC_RDY, ETOF_DAT_RDY);
      end
      if (ETOF_DAT_VLD && ETOF_DAT_RDY) begin
        got = {ETOF_DAT_ADD, ETOF_DAT_DAT, ETOF_DAT_LST};
        exp = (wq.size() > 0) ? wq.pop_front() : 17'h1ffff;
        tests_run++;
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL write_beat: got add/dat/lst %h/%h/%b, want %h/%h/%b",
                   got[16:5], got[4:1], got[0], exp[16:5], exp[4:1], exp[0]);
        end
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 500) begin
      tests_run++; tests_failed++;
      $display("FAIL write_timeout: got %0d beats, want %0d", sent, int'(len) + 1);
    end
    ETOF_DAT_RDY = 1'b1;
    #1;
    tests_run++;
    if ({IS_IDLE, ETOF_DAT_VLD} !== 2'b10) begin
      tests_failed++;
      $display("FAIL write_end_idle: IS_IDLE/ETOF_DAT_VLD got %b/%b, want 1/0",
               IS_IDLE, ETOF_DAT_VLD);
    end
    SRC_VLD = 1'b0;
  endtask

  task automatic run_read(input logic [11:0] base, input logic [11:0] len,
                          input int hold, input int rdy_pct);
    int issued = 0;
    int got = 0;
    int rcv = 0;
    int cyc = 0;
    int exp_iss;
    logic [12:0] ea;
    logic [4:0] es;
    aq.delete();
    sq.delete();
    for (int i = 0; i <= int'(len); i++) begin
      aq.push_back({base + 12'(i), (i == int'(len))});
      sq.push_back({ref_mem[base + 12'(i)], (i == int'(len))});
    end
    exp_iss = (int'(len) + 1 < OSD) ? int'(len) + 1 : OSD;
    send_cmd(1'b1, base, len);
    while (got <= int'(len) && cyc < 2000) begin
      SNK_RDY = (cyc >= hold) && ($urandom_range(99) < rdy_pct);
      #1;
      if (hold > 0 && cyc == hold) begin
        tests_run++;
        if (issued != exp_iss || (int'(len) + 1 > OSD && ETOF_ADD_VLD !== 1'b0)) begin
          tests_failed++;
          $display("FAIL credit_stall: issued %0d vld %b, want %0d vld 0",
                   issued, ETOF_ADD_VLD, exp_iss);
        end
      end
      tests_run++;
      if (ERR_LST !== err_exp) begin
        tests_failed++;
        $display("FAIL err_lst: got %b, want %b", ERR_LST, err_exp);
      end
      if (FTOE_DAT_VLD) begin
        if (FTOE_DAT_LST !== (rcv == int'(len))) err_exp = 1'b1;
        rcv++;
      end
      if (ETOF_ADD_VLD && ETOF_ADD_RDY) begin
        ea = (aq.size() > 0) ? aq.pop_front() : 13'h1fff;
        tests_run++;
        if ({ETOF_ADD_ADD, ETOF_ADD_LST} !== ea) begin
          tests_failed++;
          $display("FAIL read_addr: got add/lst %h/%b, want %h/%b",
                   ETOF_ADD_ADD, ETOF_ADD_LST, ea[12:1], ea[0]);
        end
        issued++;
      end
      if (SNK_VLD && SNK_RDY) begin
        es = (sq.size() > 0) ? sq.pop_front() : 5'h1f;
        tests_run++;
        if ({SNK_DAT, SNK_LST} !== es) begin
          tests_failed++;
          $display("FAIL snk_beat %0d: got dat/lst %h/%b, want %h/%b",
                   got, SNK_DAT, SNK_LST, es[4:1], es[0]);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) begin
      tests_run++; tests_failed++;
      $display("FAIL read_timeout: got %0d words, want %0d", got, int'(len) + 1);
    end
    SNK_RDY = 1'b0;
    #1;
    tests_run++;
    if (IS_IDLE !== 1'b1 || issued != int'(len) + 1) begin
      tests_failed++;
      $display("FAIL read_end: IS_IDLE %b issued %0d, want 1 and %0d",
               IS_IDLE, issued, int'(len) + 1);
    end
  endtask

  task automatic test_write_burst();
    run_write(12'h010, 12'd3, 4'd1, 100);
  endtask

  task automatic test_read_burst();
    run_read(12'h010, 12'd3, 0, 100);
  endtask

  task automatic test_backpressure();
    run_write(12'h100, 12'd9, 4'd3, 80);
    run_read(12'h100, 12'd9, 20, 60);
  endtask

  task automatic test_wrap_single();
    run_write(12'hFFE, 12'd2, 4'd5, 70);
    run_read(12'hFFE, 12'd0, 0, 100);
    run_read(12'hFFF, 12'd1, 0, 100);
  endtask

  task automatic test_lst_mismatch();
    flip_en = 1'b1;
    flip_addr = 12'h011;
    run_read(12'h010, 12'd3, 0, 100);
    flip_en = 1'b0;
    tests_run++;
    if (ERR_LST !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: got %b, want 1", ERR_LST);
    end
  endtask

  task automatic test_reset_mid_read();
    int rcv = 0;
    int cyc = 0;
    logic [10:0] obs;
    send_cmd(1'b1, 12'h100, 12'd3);
    SNK_RDY = 1'b0;
    while (rcv < 2 && cyc < 100) begin
      #1;
      if (FTOE_DAT_VLD) rcv++;
      @(negedge clk);
      cyc++;
    end
    #1;
    tests_run++;
    if (rcv < 2 || SNK_VLD !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_read_fill: got %0d returns snk_vld %b, want 2 and 1", rcv, SNK_VLD);
    end
    rst_n = 1'b0;
    #1;
    obs = {IS_IDLE, CMD_RDY, FTOE_DAT_RDY, ETOF_DAT_VLD, ETOF_DAT_LST, ETOF_ADD_VLD,
           ETOF_ADD_LST, SNK_VLD, SNK_LST, ERR_LST, SRC_RDY};
    tests_run++;
    if (obs !== 11'b111_0000_0000) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got %b, want 11100000000", obs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    err_exp = 1'b0;
    run_read(12'h010, 12'd3, 0, 100);
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_backpressure();
    test_wrap_single();
    test_lst_mismatch();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
